// File: rtl/rx_port_arbiter_pkg.sv
// Shared types and word-format constants for the receive-port arbiter and its
// round-robin picker.
package rx_port_arbiter_pkg;

   typedef enum logic [1:0] {
      ARB   = 2'b00,
      XFER  = 2'b01,
      CLOSE = 2'b10
   } arb_state_t;

   localparam int         FLAG_BIT   = 8;
   localparam int         DATA_MSB   = 7;
   localparam logic [8:0] CLOSE_WORD = 9'h000;

   // A cleared flag bit marks the end-of-frame terminator; its payload is ignored.
   function automatic logic is_terminator(input logic [8:0] word);
      return ~word[FLAG_BIT];
   endfunction

   function automatic logic [8:0] data_word(input logic [DATA_MSB:0] byte_val);
      return {1'b1, byte_val};
   endfunction

endpackage

// File: rtl/rx_port_arbiter_rr_pick.sv
// Combinational round-robin picker: the first requester after 'last' (wrapping)
// wins. Shared with the tx-side scheduler.
module rr_pick #(
   parameter int N = 4,
   parameter int W = 2
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] last,
   output logic [N-1:0] gnt_oh,
   output logic [W-1:0] gnt_idx,
   output logic         gnt_valid
);

   logic [W-1:0] cand_s;

   // Scan from the farthest offset to the nearest so the nearest requester overwrites.
   always_comb begin
      cand_s    = W'(0);
      gnt_idx   = W'(0);
      gnt_valid = 1'b0;
      for (int i = N; i >= 1; i--) begin
         cand_s    = W'((int'(last) + i) % N);
         gnt_idx   = req[cand_s] ? cand_s : gnt_idx;
         gnt_valid = req[cand_s] | gnt_valid;
      end
   end

   assign gnt_oh = gnt_valid ? (N'(1) << gnt_idx) : N'(0);

endmodule

// File: rtl/rx_port_arbiter.sv
// Frame-granular round-robin drain of NPORTS receive FIFOs into one stream.
// Build option RX_PORT_ARBITER_PRIO_EN gives port 0 strict priority in arbitration.
module rx_port_arbiter
   import rx_port_arbiter_pkg::*;
#(
   parameter int NPORTS      = 4,
   parameter int PW          = 2,
   parameter int GAP_TIMEOUT = 64
) (
   input  logic                  sys_clk,
   input  logic                  sys_rst,
   input  logic [NPORTS-1:0]     rx_empty,
   input  logic [9*NPORTS-1:0]   rx_data,
   output logic [NPORTS-1:0]     rx_rd_en,
   output logic [8:0]            out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  out_sof,
   output logic                  out_eof,
   output logic                  out_err,
   output logic [PW-1:0]         out_port
);

   localparam logic [15:0] GAP_LAST = 16'(GAP_TIMEOUT - 1);

   arb_state_t        state_r, state_nxt_s;
   logic [PW-1:0]     grant_r, last_grant_r;
   logic [NPORTS-1:0] grant_oh_r;
   logic              first_r;
   logic [15:0]       gap_cnt_r;
   logic [8:0]        out_data_r;
   logic              out_valid_r, out_sof_r, out_eof_r, out_err_r;
   logic [PW-1:0]     out_port_r;

   logic [8:0]        rx_word_s [NPORTS];
   logic [NPORTS-1:0] rr_req_s, rr_oh_s, pick_oh_s, rd_en_s;
   logic [PW-1:0]     rr_idx_s, pick_idx_s;
   logic              rr_valid_s, pick_valid_s, pick_upd_s;
   logic              load_ok_s, cur_empty_s, load_s, load_eof_s, load_err_s;
   logic [8:0]        cur_word_s, load_word_s;

   for (genvar i = 0; i < NPORTS; i++) begin : g_word
      assign rx_word_s[i] = rx_data[9*i +: 9];
   end

   assign cur_word_s  = rx_word_s[grant_r];
   assign cur_empty_s = rx_empty[grant_r];
   assign load_ok_s   = ~out_valid_r | out_ready;

`ifdef RX_PORT_ARBITER_PRIO_EN
   // Port 0 pre-empts the rotation and does not move the round-robin pointer.
   assign rr_req_s     = ~rx_empty & ~NPORTS'(1);
   assign pick_valid_s = ~rx_empty[0] | rr_valid_s;
   assign pick_idx_s   = ~rx_empty[0] ? PW'(0) : rr_idx_s;
   assign pick_oh_s    = ~rx_empty[0] ? NPORTS'(1) : rr_oh_s;
   assign pick_upd_s   = rx_empty[0];
`else
   assign rr_req_s     = ~rx_empty;
   assign pick_valid_s = rr_valid_s;
   assign pick_idx_s   = rr_idx_s;
   assign pick_oh_s    = rr_oh_s;
   assign pick_upd_s   = 1'b1;
`endif

   rr_pick #(.N(NPORTS), .W(PW)) u_rr_pick (
      .req       (rr_req_s),
      .last      (last_grant_r),
      .gnt_oh    (rr_oh_s),
      .gnt_idx   (rr_idx_s),
      .gnt_valid (rr_valid_s)
   );

   // State register.
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) state_r <= ARB;
      else         state_r <= state_nxt_s;
   end

   // Next-state logic; data arriving on the timeout cycle beats the close.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ARB: begin
            if (pick_valid_s) state_nxt_s = XFER;
            else              state_nxt_s = ARB;
         end
         XFER: begin
            if (!cur_empty_s) begin
               if (load_ok_s && is_terminator(cur_word_s)) state_nxt_s = ARB;
               else                                       state_nxt_s = XFER;
            end else if (gap_cnt_r == GAP_LAST) begin
               state_nxt_s = CLOSE;
            end else begin
               state_nxt_s = XFER;
            end
         end
         CLOSE: begin
            if (load_ok_s) state_nxt_s = ARB;
            else           state_nxt_s = CLOSE;
         end
         default: state_nxt_s = ARB;
      endcase
   end

   // Pop strobe and output-register load selection.
   always_comb begin
      rd_en_s     = NPORTS'(0);
      load_s      = 1'b0;
      load_word_s = CLOSE_WORD;
      load_eof_s  = 1'b0;
      load_err_s  = 1'b0;
      case (state_r)
         XFER: begin
            if (!cur_empty_s && load_ok_s) begin
               rd_en_s     = grant_oh_r;
               load_s      = 1'b1;
               load_word_s = cur_word_s;
               load_eof_s  = is_terminator(cur_word_s);
            end else begin
               load_s      = 1'b0;
            end
         end
         CLOSE: begin
            if (load_ok_s) begin
               load_s     = 1'b1;
               load_eof_s = 1'b1;
               load_err_s = 1'b1;
            end else begin
               load_s     = 1'b0;
            end
         end
         default: load_s = 1'b0;
      endcase
   end

   // Grant, rotation pointer, first-beat flag and mid-frame gap counter.
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         grant_r      <= PW'(0);
         grant_oh_r   <= NPORTS'(0);
         last_grant_r <= PW'(NPORTS - 1);
         first_r      <= 1'b0;
         gap_cnt_r    <= 16'd0;
      end else begin
         case (state_r)
            ARB: begin
               if (pick_valid_s) begin
                  grant_r    <= pick_idx_s;
                  grant_oh_r <= pick_oh_s;
                  first_r    <= 1'b1;
                  gap_cnt_r  <= 16'd0;
                  if (pick_upd_s) last_grant_r <= pick_idx_s;
               end
            end
            XFER: begin
               if (load_s) begin
                  first_r   <= 1'b0;
                  gap_cnt_r <= 16'd0;
               end else if (cur_empty_s) begin
                  gap_cnt_r <= gap_cnt_r + 16'd1;
               end
            end
            CLOSE: begin
               gap_cnt_r <= 16'd0;
               if (load_s) first_r <= 1'b0;
            end
            default: gap_cnt_r <= 16'd0;
         endcase
      end
   end

   // Single-entry output register.
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         out_data_r  <= 9'h000;
         out_valid_r <= 1'b0;
         out_sof_r   <= 1'b0;
         out_eof_r   <= 1'b0;
         out_err_r   <= 1'b0;
         out_port_r  <= PW'(0);
      end else if (load_s) begin
         out_data_r  <= load_word_s;
         out_valid_r <= 1'b1;
         out_sof_r   <= first_r;
         out_eof_r   <= load_eof_s;
         out_err_r   <= load_err_s;
         out_port_r  <= grant_r;
      end else if (out_valid_r && out_ready) begin
         out_valid_r <= 1'b0;
      end
   end

   assign rx_rd_en  = rd_en_s;
   assign out_data  = out_data_r;
   assign out_valid = out_valid_r;
   assign out_sof   = out_sof_r;
   assign out_eof   = out_eof_r;
   assign out_err   = out_err_r;
   assign out_port  = out_port_r;

endmodule

// File: tb/tb_rx_port_arbiter.sv
// Directed bench for rx_port_arbiter: FIFO models per port, accepted-beat log,
// hand-computed expected beats. Honours RX_PORT_ARBITER_PRIO_EN when defined.
module tb_rx_port_arbiter;
   import rx_port_arbiter_pkg::*;

   localparam int NP = 4;

   logic            sys_clk = 1'b0;
   logic            sys_rst = 1'b1;
   logic [NP-1:0]   rx_empty;
   logic [9*NP-1:0] rx_data;
   logic [NP-1:0]   rx_rd_en;
   logic [8:0]      out_data;
   logic            out_valid;
   logic            out_ready;
   logic            out_sof, out_eof, out_err;
   logic [1:0]      out_port;

   typedef struct {
      logic [8:0] d;
      logic       sof;
      logic       eof;
      logic       err;
      logic [1:0] port;
      int         cyc;
   } beat_t;

   logic [8:0]    fq [NP][$];
   beat_t         beats [$];
   int            pops [NP];
   int            checks = 0;
   int            failures = 0;
   int            cyc = 0;
   logic          toggle_ready = 1'b0;
   logic [NP-1:0] pend_pop;
   logic          stall_prev = 1'b0;
   logic [8:0]    stall_data;

   rx_port_arbiter #(.NPORTS(NP), .PW(2), .GAP_TIMEOUT(64)) dut (
      .sys_clk   (sys_clk),
      .sys_rst   (sys_rst),
      .rx_empty  (rx_empty),
      .rx_data   (rx_data),
      .rx_rd_en  (rx_rd_en),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sof   (out_sof),
      .out_eof   (out_eof),
      .out_err   (out_err),
      .out_port  (out_port)
   );

   always #5 sys_clk = ~sys_clk;

   initial begin
      #100000;
      $display("FAIL watchdog: observed no finish, expected finish before 100000");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic drive_fifos();
      for (int i = 0; i < NP; i++) begin
         rx_empty[i]       = (fq[i].size() == 0);
         rx_data[9*i +: 9] = (fq[i].size() == 0) ? 9'h000 : fq[i][0];
      end
   endtask

   // One clock: observe at the falling edge, apply pops and new inputs after the rising edge.
   task automatic step();
      beat_t b;
      @(negedge sys_clk);
      cyc++;
      check("rd_onehot", 32'($countones(rx_rd_en) <= 1), 32'd1);
      if (stall_prev) check("stall_hold", 32'({out_valid, out_data}), 32'({1'b1, stall_data}));
      if (out_valid && !out_ready) check("stall_nopop", 32'(rx_rd_en), 32'd0);
      stall_prev = out_valid && !out_ready;
      stall_data = out_data;
      if (out_valid && out_ready) begin
         b.d = out_data; b.sof = out_sof; b.eof = out_eof; b.err = out_err;
         b.port = out_port; b.cyc = cyc;
         beats.push_back(b);
      end
      pend_pop = rx_rd_en;
      @(posedge sys_clk);
      #1;
      for (int i = 0; i < NP; i++) begin
         if (pend_pop[i]) begin
            check($sformatf("pop_nonempty%0d", i), 32'(fq[i].size() != 0), 32'd1);
            if (fq[i].size() != 0) begin
               void'(fq[i].pop_front());
               pops[i]++;
            end
         end
      end
      if (toggle_ready) out_ready = ~out_ready;
      drive_fifos();
   endtask

   task automatic run(input int n);
      repeat (n) step();
   endtask

   task automatic clear_log();
      beats.delete();
      for (int i = 0; i < NP; i++) pops[i] = 0;
   endtask

   task automatic do_reset();
      sys_rst = 1'b1;
      for (int i = 0; i < NP; i++) fq[i].delete();
      out_ready    = 1'b1;
      toggle_ready = 1'b0;
      drive_fifos();
      repeat (2) @(posedge sys_clk);
      #1;
      sys_rst    = 1'b0;
      stall_prev = 1'b0;
      clear_log();
   endtask

   task automatic check_beat(input int idx, input logic [8:0] d, input logic sof,
                             input logic eof, input logic err, input logic [1:0] port);
      if (idx < beats.size())
         check($sformatf("beat%0d", idx),
               32'({beats[idx].port, beats[idx].err, beats[idx].eof, beats[idx].sof, beats[idx].d}),
               32'({port, err, eof, sof, d}));
      else
         check($sformatf("beat%0d_missing", idx), 32'd0, 32'd1);
   endtask

   task automatic check_gap(input string tag, input int idx, input int exp_gap);
      if (idx < beats.size() && idx > 0)
         check(tag, 32'(beats[idx].cyc - beats[idx-1].cyc), 32'(exp_gap));
      else
         check({tag, "_missing"}, 32'd0, 32'd1);
   endtask

   initial begin
      int order [6] = '{0, 1, 3, 0, 1, 3};
      int pr [5];
      logic [8:0] pd [5];

      // Reset state
      do_reset();
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_rd_en", 32'(rx_rd_en), 32'd0);
      check("rst_flags", 32'({out_sof, out_eof, out_err}), 32'd0);
      check("rst_port_data", 32'({out_port, out_data}), 32'd0);

      // Single frame on port 2
      fq[2] = '{data_word(8'h55), data_word(8'hAA), data_word(8'h01), 9'h000};
      drive_fifos();
      run(10);
      check("single_nbeats", 32'(beats.size()), 32'd4);
      check_beat(0, 9'h155, 1'b1, 1'b0, 1'b0, 2'd2);
      check_beat(1, 9'h1AA, 1'b0, 1'b0, 1'b0, 2'd2);
      check_beat(2, 9'h101, 1'b0, 1'b0, 1'b0, 2'd2);
      check_beat(3, 9'h000, 1'b0, 1'b1, 1'b0, 2'd2);
      check("single_pops2", 32'(pops[2]), 32'd4);
      check_gap("single_rate", 1, 1);

      // Fairness: ports 0,1,3 with two 2-byte frames each
      do_reset();
      fq[0] = '{9'h100, 9'h101, 9'h000, 9'h102, 9'h103, 9'h000};
      fq[1] = '{9'h110, 9'h111, 9'h000, 9'h112, 9'h113, 9'h000};
      fq[3] = '{9'h130, 9'h131, 9'h000, 9'h132, 9'h133, 9'h000};
      drive_fifos();
      run(32);
      check("fair_nbeats", 32'(beats.size()), 32'd18);
      for (int f = 0; f < 6; f++) begin
         check_beat(3*f,   9'(9'h100 + 16*order[f] + 2*(f/3)),     1'b1, 1'b0, 1'b0, 2'(order[f]));
         check_beat(3*f+1, 9'(9'h100 + 16*order[f] + 2*(f/3) + 1), 1'b0, 1'b0, 1'b0, 2'(order[f]));
         check_beat(3*f+2, 9'h000, 1'b0, 1'b1, 1'b0, 2'(order[f]));
         if (f > 0) check_gap($sformatf("fair_arb_gap%0d", f), 3*f, 2);
      end

      // Backpressure: out_ready toggles every cycle during a frame on port 1
      clear_log();
      fq[1] = '{9'h1A0, 9'h1A1, 9'h1A2, 9'h1A3, 9'h1A4, 9'h000};
      drive_fifos();
      toggle_ready = 1'b1;
      run(30);
      toggle_ready = 1'b0;
      out_ready    = 1'b1;
      run(2);
      check("bp_nbeats", 32'(beats.size()), 32'd6);
      for (int k = 0; k < 5; k++)
         check_beat(k, 9'(9'h1A0 + k), (k == 0), 1'b0, 1'b0, 2'd1);
      check_beat(5, 9'h000, 1'b0, 1'b1, 1'b0, 2'd1);
      check("bp_pops1", 32'(pops[1]), 32'd6);

      // Gap timeout: two bytes then 64 empty cycles
      clear_log();
      fq[1] = '{9'h111, 9'h122};
      drive_fifos();
      run(80);
      check("gap_nbeats", 32'(beats.size()), 32'd3);
      check_beat(0, 9'h111, 1'b1, 1'b0, 1'b0, 2'd1);
      check_beat(1, 9'h122, 1'b0, 1'b0, 1'b0, 2'd1);
      check_beat(2, 9'h000, 1'b0, 1'b1, 1'b1, 2'd1);
      check_gap("gap_close_time", 2, 65);
      fq[1] = '{9'h133, 9'h000};
      drive_fifos();
      run(10);
      check_beat(3, 9'h133, 1'b1, 1'b0, 1'b0, 2'd1);
      check_beat(4, 9'h000, 1'b0, 1'b1, 1'b0, 2'd1);

      // Asynchronous reset mid-frame
      clear_log();
      fq[2] = '{9'h1B0, 9'h1B1, 9'h1B2, 9'h1B3, 9'h1B4, 9'h1B5, 9'h000};
      drive_fifos();
      run(3);
      check("pre_rst_busy", 32'({out_valid, rx_rd_en}), 32'({1'b1, 4'b0100}));
      #2;
      sys_rst = 1'b1;
      #1;
      check("rst_async_valid", 32'(out_valid), 32'd0);
      check("rst_async_rd_en", 32'(rx_rd_en), 32'd0);
      for (int i = 0; i < NP; i++) fq[i].delete();
      drive_fifos();
      @(posedge sys_clk);
      #1;
      sys_rst    = 1'b0;
      stall_prev = 1'b0;
      clear_log();
      fq[3] = '{9'h1C3, 9'h000};
      fq[0] = '{9'h1C0, 9'h000};
      drive_fifos();
      run(12);
      check_beat(0, 9'h1C0, 1'b1, 1'b0, 1'b0, 2'd0);
      check_beat(2, 9'h1C3, 1'b1, 1'b0, 1'b0, 2'd3);

      // Ports 0 and 2 both backlogged: strict priority or plain rotation
      do_reset();
      fq[0] = '{9'h1D0, 9'h000, 9'h1D1, 9'h000, 9'h1D2, 9'h000};
      fq[2] = '{9'h1E0, 9'h000, 9'h1E1, 9'h000};
      drive_fifos();
      run(25);
`ifdef RX_PORT_ARBITER_PRIO_EN
      pr = '{0, 0, 0, 2, 2};
      pd = '{9'h1D0, 9'h1D1, 9'h1D2, 9'h1E0, 9'h1E1};
`else
      pr = '{0, 2, 0, 2, 0};
      pd = '{9'h1D0, 9'h1E0, 9'h1D1, 9'h1E1, 9'h1D2};
`endif
      check("mix_nbeats", 32'(beats.size()), 32'd10);
      for (int f = 0; f < 5; f++) begin
         check_beat(2*f,   pd[f],  1'b1, 1'b0, 1'b0, 2'(pr[f]));
         check_beat(2*f+1, 9'h000, 1'b0, 1'b1, 1'b0, 2'(pr[f]));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
